// File: rtl/rnn_state_argmax.sv
// Snoops hidden-state writebacks from the RNN core and reports the per-timestep
// argmax {timestep, neuron index, value} through a small ready/valid FIFO.
module rnn_state_argmax #(
  parameter int unsigned HSIZE      = 64,
  parameter logic [2:0]  WSEL       = 3'b101,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mce,
  input  logic [2:0]  msel,
  input  logic [16:0] maddr,
  input  logic [19:0] mdata_w,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [10:0] o_t,
  output logic [5:0]  o_idx,
  output logic [19:0] o_max,
  output logic        ovf,
  output logic        seq_err
);

  localparam int unsigned IW = $clog2(HSIZE);
  localparam int unsigned TW = 11;
  localparam int unsigned DW = 20;
  localparam int unsigned RW = TW + IW + DW;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Capture stage
  logic          cap_v;
  logic [TW-1:0] cap_t;
  logic [IW-1:0] cap_h;
  logic [DW-1:0] cap_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_v <= 1'b0;
      cap_t <= '0;
      cap_h <= '0;
      cap_d <= '0;
    end else begin
      cap_v <= mce && (msel == WSEL);
      cap_t <= maddr[TW+IW-1:IW];
      cap_h <= maddr[IW-1:0];
      cap_d <= mdata_w;
    end
  end

  // Running argmax; active drops when a timestep is abandoned on a sequence error
  logic [IW-1:0] exp_h;
  logic [DW-1:0] cur_max;
  logic [IW-1:0] cur_idx;
  logic [TW-1:0] cur_t;
  logic          active;

  logic          restart_c;
  logic          accept_c;
  logic          better_c;
  logic [DW-1:0] fin_max_c;
  logic [IW-1:0] fin_idx_c;
  logic          push_req_c;
  logic [RW-1:0] push_rec_c;

  always_comb begin
    restart_c  = cap_v && (cap_h == '0);
    accept_c   = cap_v && ((cap_h == exp_h) || restart_c);
    better_c   = $signed(cap_d) > $signed(cur_max);
    fin_max_c  = cur_max;
    fin_idx_c  = cur_idx;
    if (restart_c || better_c) begin
      fin_max_c = cap_d;
      fin_idx_c = cap_h;
    end
    push_req_c = accept_c && !restart_c && active && (cap_h == IW'(HSIZE - 1));
    push_rec_c = {cur_t, fin_idx_c, fin_max_c};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_h   <= '0;
      cur_max <= '0;
      cur_idx <= '0;
      cur_t   <= '0;
      active  <= 1'b0;
      seq_err <= 1'b0;
    end else if (cap_v) begin
      if (cap_h != exp_h) seq_err <= 1'b1;
      if (accept_c) begin
        exp_h   <= cap_h + IW'(1);
        cur_max <= fin_max_c;
        cur_idx <= fin_idx_c;
        if (restart_c) begin
          cur_t  <= cap_t;
          active <= 1'b1;
        end
      end else begin
        active <= 1'b0;
      end
    end
  end

  // Result FIFO with the head copied into the output registers one edge ahead
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          pop_c;
  logic          full_c;
  logic          do_push_c;
  logic [PW-1:0] rd_nxt_c;
  logic [CW-1:0] count_nxt_c;
  logic [RW-1:0] head_nxt_c;

  always_comb begin
    pop_c       = o_valid && o_ready;
    full_c      = (count == CW'(FIFO_DEPTH));
    do_push_c   = push_req_c && (!full_c || pop_c);
    rd_nxt_c    = pop_c ? rd_ptr + PW'(1) : rd_ptr;
    count_nxt_c = count + CW'(do_push_c) - CW'(pop_c);
    head_nxt_c  = mem[rd_nxt_c];
    if (do_push_c && (wr_ptr == rd_nxt_c)) head_nxt_c = push_rec_c;
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= push_rec_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      o_valid <= 1'b0;
      o_t     <= '0;
      o_idx   <= '0;
      o_max   <= '0;
      ovf     <= 1'b0;
    end else begin
      rd_ptr  <= rd_nxt_c;
      count   <= count_nxt_c;
      o_valid <= (count_nxt_c != '0);
      if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
      if (count_nxt_c != '0) {o_t, o_idx, o_max} <= head_nxt_c;
      if (push_req_c && full_c && !pop_c) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rnn_state_argmax.sv
// Directed bench for rnn_state_argmax: argmax records, FIFO backpressure,
// sequence errors, bus filtering and mid-timestep reset.
module tb_rnn_state_argmax;

  logic        clk = 1'b0;
  logic        reset;
  logic        mce;
  logic [2:0]  msel;
  logic [16:0] maddr;
  logic [19:0] mdata_w;
  logic        o_valid;
  logic        o_ready;
  logic [10:0] o_t;
  logic [5:0]  o_idx;
  logic [19:0] o_max;
  logic        ovf;
  logic        seq_err;

  int n_vec = 0;
  int n_err = 0;
  int vcnt;

  rnn_state_argmax dut (
    .clk(clk), .reset(reset), .mce(mce), .msel(msel), .maddr(maddr),
    .mdata_w(mdata_w), .o_valid(o_valid), .o_ready(o_ready), .o_t(o_t),
    .o_idx(o_idx), .o_max(o_max), .ovf(ovf), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wr(input int t, input int h, input logic [19:0] d,
                    input logic [2:0] sel = 3'b101, input logic en = 1'b1);
    mce     = en;
    msel    = sel;
    maddr   = {11'(t), 6'(h)};
    mdata_w = d;
    tick();
  endtask

  task automatic idle();
    mce     = 1'b0;
    msel    = 3'b000;
    maddr   = '0;
    mdata_w = '0;
    tick();
  endtask

  task automatic chk_rec(input string tag, input int t, input int idx, input logic [19:0] mx);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_t"}, 32'(o_t), 32'(t));
    chk({tag, "_idx"}, 32'(o_idx), 32'(idx));
    chk({tag, "_max"}, 32'(o_max), 32'(mx));
  endtask

  initial begin
    reset = 1'b0; mce = 1'b0; msel = '0; maddr = '0; mdata_w = '0; o_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_t", 32'(o_t), 32'd0);
    chk("rst_idx", 32'(o_idx), 32'd0);
    chk("rst_max", 32'(o_max), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_seq", 32'(seq_err), 32'd0);
    reset = 1'b1;
    tick();

    // Ramp: max at the last neuron, valid two edges after the last write
    for (int h = 0; h < 64; h++) wr(5, h, 20'(h * 256));
    chk("ramp_e0_valid", 32'(o_valid), 32'd0);
    idle();
    chk_rec("ramp", 5, 63, 20'h03F00);
    idle();
    chk("ramp_one_cycle", 32'(o_valid), 32'd0);

    // Ties and negatives: two +1.0 entries, lower index wins
    for (int h = 0; h < 64; h++) wr(7, h, (h == 10 || h == 40) ? 20'h10000 : 20'hF0000);
    idle();
    chk_rec("tie", 7, 10, 20'h10000);
    idle();

    // Backpressure: four records fill the FIFO, two more are dropped
    o_ready = 1'b0;
    for (int t = 0; t < 4; t++)
      for (int h = 0; h < 64; h++) wr(t, h, (h == t + 3) ? 20'(256 * (t + 1)) : 20'h0);
    idle();
    chk("bp_no_ovf", 32'(ovf), 32'd0);
    for (int t = 4; t < 6; t++)
      for (int h = 0; h < 64; h++) wr(t, h, (h == t + 3) ? 20'(256 * (t + 1)) : 20'h0);
    idle(); idle();
    chk("bp_ovf", 32'(ovf), 32'd1);
    chk_rec("bp_held", 0, 3, 20'h00100);
    o_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_rec($sformatf("drain%0d", i), i, i + 3, 20'(256 * (i + 1)));
      tick();
    end
    chk("drain_empty", 32'(o_valid), 32'd0);

    // Sequence error: skip h=21, timestep abandoned, next clean one reported
    for (int h = 0; h <= 20; h++) wr(9, h, 20'h00050);
    idle();
    chk("seq_before", 32'(seq_err), 32'd0);
    wr(9, 22, 20'h00050);
    idle();
    chk("seq_set", 32'(seq_err), 32'd1);
    chk("seq_no_rec", 32'(o_valid), 32'd0);
    for (int h = 0; h < 64; h++) wr(10, h, (h == 33) ? 20'h0C000 : 20'h00050);
    idle();
    chk_rec("seq_clean", 10, 33, 20'h0C000);
    idle();

    // Filtering: other selects and mce=0 with large data must be ignored
    for (int h = 0; h < 64; h++) begin
      wr(11, h, 20'h0FFFF, 3'b000, 1'b1);
      wr(11, 0, 20'h0FFFF, 3'b010, 1'b1);
      wr(11, h, 20'h0FFFF, 3'b101, 1'b0);
      wr(11, h, (h == 17) ? 20'h08000 : 20'(h));
    end
    idle();
    chk_rec("filter", 11, 17, 20'h08000);
    idle();

    // Reset mid-timestep: partial state discarded, no partial record
    for (int h = 0; h <= 30; h++) wr(12, h, 20'h0A000);
    reset = 1'b0;
    idle();
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_t", 32'(o_t), 32'd0);
    chk("mrst_max", 32'(o_max), 32'd0);
    chk("mrst_seq", 32'(seq_err), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    reset = 1'b1;
    vcnt = 0;
    for (int h = 31; h < 64; h++) begin
      wr(12, h, 20'h0A000);
      if (o_valid) vcnt++;
    end
    idle();
    if (o_valid) vcnt++;
    idle();
    if (o_valid) vcnt++;
    chk("mrst_no_partial", 32'(vcnt), 32'd0);
    chk("mrst_tail_seq", 32'(seq_err), 32'd1);
    for (int h = 0; h < 64; h++) wr(13, h, 20'h0 - 20'(h));
    idle();
    chk_rec("mrst_after", 13, 0, 20'h00000);
    idle();
    chk("final_empty", 32'(o_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rnn_state_argmax.md
Name: rnn_state_argmax

Overview:
- Passive downstream consumer of the RNN core's hidden-state writeback bus. Snoops every memory write with msel = 3'b101 and reassembles the 64 hidden values of each timestep.
- Tracks the per-timestep maximum and its neuron index.
- Emits one {timestep, index, value} record per completed timestep through a small ready/valid FIFO, for the classifier/host side.
- Never drives the memory bus.

Parameters:
- HSIZE, 64, hidden neurons per timestep (power of 2; index width = log2(HSIZE) = 6)
- WSEL, 3'b101, msel value that marks a hidden-state writeback
- FIFO_DEPTH, 4, result FIFO entries (power of 2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- mce  in  1  memory chip enable from RNN core
- msel  in  3  memory select from RNN core
- maddr  in  17  address; [16:6] = timestep t, [5:0] = neuron h
- mdata_w  in  20  signed Q4.16 hidden value, already clipped to [-1.0, +1.0]
- o_valid  out  1  result record available
- o_ready  in  1  consumer accepts record when o_valid & o_ready
- o_t  out  11  timestep of record
- o_idx  out  6  neuron index of maximum
- o_max  out  20  signed maximum value
- ovf  out  1  sticky: a record was dropped (FIFO full)
- seq_err  out  1  sticky: out-of-order neuron index seen

Behaviour:
- Reset (reset == 0 at a clock edge): o_valid = 0, o_t/o_idx/o_max = 0, ovf = 0, seq_err = 0, FIFO empty, exp_h = 0, running max cleared. Reset mid-timestep discards partial state; no record is emitted for it.
- Capture, edge E0: a write is taken when mce == 1 and msel == WSEL. {t, h, data} are registered into cap_* with cap_v = 1. Every other msel, or mce = 0, is ignored (cap_v = 0).
- Update, edge E1, when cap_v = 1:
  - h == 0: start a new timestep. cur_max = data, cur_idx = 0, cur_t = t.
  - 0 < h == exp_h: if data > cur_max (signed compare), load cur_max = data and cur_idx = h. Ties keep the lower index.
  - h != exp_h: set seq_err. If h == 0, treat as a restart (above). Otherwise drop the sample and hold exp_h; the timestep is abandoned and no record is pushed until the next h == 0.
  - exp_h = h + 1 (mod HSIZE) after every accepted sample.
  - h == HSIZE-1 and accepted: push {cur_t, final idx, final max} into the FIFO. The final values include this sample's comparison.
- Latency: last write sampled at E0 -> o_valid = 1 after E1 when the FIFO was empty.
- FIFO:
  - Registered head; o_t/o_idx/o_max are valid whenever o_valid = 1 and are stable while o_valid & !o_ready.
  - Pop on o_valid & o_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Full with a push and no pop: the record is dropped and ovf set. Full with push and pop together: no drop.
  - Empty with a push: o_valid rises after that edge. There is no same-cycle bypass.
- ovf and seq_err clear only on reset.
- Back-to-back writes every cycle are sustained indefinitely (throughput 1 sample/clk). Consecutive timesteps may abut; the h == 0 of t+1 may arrive the cycle after h == 63 of t.
- Timestep wrap: t is taken from maddr verbatim and is not checked for monotonicity.

Test Plan:
- Ramp: one timestep t = 5, data[h] = h*0x100, writes on consecutive cycles, o_ready = 1 -> single record o_t = 5, o_idx = 63, o_max = 0x03F00, o_valid for 1 cycle, 2 edges after last write.
- Ties and negatives: all values 0xF0000 (-1.0) except h = 10 and h = 40 = 0x10000 -> o_idx = 10, o_max = 0x10000.
- Backpressure: o_ready = 0, six full timesteps t = 0..5 -> first 4 records held in order; t = 4 and t = 5 are dropped; ovf = 1. Raise o_ready -> records t = 0..3 drain, one per cycle, then o_valid = 0.
- Sequence error: h = 0..20, then h = 22 -> seq_err = 1 and no record for that t. A following clean 0..63 timestep yields a normal record.
- Filtering: interleave writes with msel = 3'b000/3'b010 and mce = 0 cycles carrying large data -> ignored; the record matches msel = 101 data only.
- Reset mid-timestep: reset low for 1 cycle after h = 30 -> all outputs 0, FIFO empty. A later full timestep produces a correct record; no partial record appears.
